apuf_crp_ctrl: RTL and testbench

APUF_CRP_CTRL -- requirements
Module: apuf_crp_ctrl

---
 rtl/apuf_crp_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_apuf_crp_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apuf_crp_ctrl.sv
// Challenge/response controller for an arbiter PUF: holds a challenge on both paths,
// fires the trigger NREP times, majority-votes the synchronized arbiter output.
module apuf_crp_ctrl #(
  parameter int unsigned NSTAGE  = 128,
  parameter int unsigned NREP    = 7,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned RECOVER = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ch_valid,
  output logic              ch_ready,
  input  logic [NSTAGE-1:0] ch_data,
  output logic [NSTAGE-1:0] cT,
  output logic [NSTAGE-1:0] cB,
  output logic              tigSignal,
  input  logic              respReady,
  input  logic              respBit,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_bit,
  output logic [7:0]        resp_ones,
  output logic              resp_err
);

  localparam int unsigned SW = (SETTLE  > 1) ? $clog2(SETTLE + 1)  : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned RW = (RECOVER > 1) ? $clog2(RECOVER + 1) : 1;

  typedef enum logic [2:0] {
    StIdle, StSettle, StFire, StWait, StSample, StRelax, StDone
  } state_e;

  state_e            state_q, state_d;
  logic              rr_meta, rr_s, rb_meta, rb_s;
  logic [NSTAGE-1:0] ct_q, ct_d, cb_q, cb_d;
  logic [7:0]        ones_q, ones_d, rep_q, rep_d;
  logic              err_q, err_d;
  logic              tig_q, tig_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [RW-1:0]     rlx_q, rlx_d;
  logic              rbit_q, rbit_d, rerr_q, rerr_d;
  logic [7:0]        rones_q, rones_d;

  // Two-flop synchronizers; the raw PUF status lines are used nowhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_meta <= 1'b0;
      rr_s    <= 1'b0;
      rb_meta <= 1'b0;
      rb_s    <= 1'b0;
    end else begin
      rr_meta <= respReady;
      rr_s    <= rr_meta;
      rb_meta <= respBit;
      rb_s    <= rb_meta;
    end
  end

  // State, challenge, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ct_q     <= '0;
      cb_q     <= '0;
      ones_q   <= '0;
      rep_q    <= '0;
      err_q    <= 1'b0;
      tig_q    <= 1'b0;
      settle_q <= '0;
      tmo_q    <= '0;
      rlx_q    <= '0;
      rbit_q   <= 1'b0;
      rones_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ct_q     <= ct_d;
      cb_q     <= cb_d;
      ones_q   <= ones_d;
      rep_q    <= rep_d;
      err_q    <= err_d;
      tig_q    <= tig_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      rlx_q    <= rlx_d;
      rbit_q   <= rbit_d;
      rones_q  <= rones_d;
      rerr_q   <= rerr_d;
    end
  end

  // Next-state logic; the trigger is registered so tig_d is the value for the next cycle.
  always_comb begin
    state_d  = state_q;
    ct_d     = ct_q;
    cb_d     = cb_q;
    ones_d   = ones_q;
    rep_d    = rep_q;
    err_d    = err_q;
    tig_d    = 1'b0;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    rlx_d    = rlx_q;
    rbit_d   = rbit_q;
    rones_d  = rones_q;
    rerr_d   = rerr_q;
    unique case (state_q)
      StIdle: begin
        if (ch_valid) begin
          ct_d     = ch_data;
          cb_d     = ch_data;
          ones_d   = '0;
          rep_d    = '0;
          err_d    = 1'b0;
          settle_d = '0;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (settle_q == SW'(SETTLE - 1)) state_d = StFire;
        else settle_d = settle_q + 1'b1;
      end
      StFire: begin
        tig_d   = 1'b1;
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        tig_d = 1'b1;
        // Arrival beats timeout when both happen on the same cycle.
        if (rr_s) begin
          state_d = StSample;
        end else if (tmo_q == TW'(TIMEOUT)) begin
          tig_d   = 1'b0;
          err_d   = 1'b1;
          rlx_d   = '0;
          state_d = StRelax;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StSample: begin
        if (rep_q != 8'(NREP)) begin
          ones_d = ones_q + {7'd0, rb_s};
          rep_d  = rep_q + 8'd1;
        end
        rlx_d   = '0;
        state_d = StRelax;
      end
      StRelax: begin
        if (rr_s) begin
          rlx_d = '0;
        end else if (rlx_q == RW'(RECOVER - 1)) begin
          if (rep_q < 8'(NREP) && !err_q) begin
            state_d = StFire;
          end else begin
            rbit_d  = (ones_q > 8'(NREP / 2)) && !err_q;
            rones_d = ones_q;
            rerr_d  = err_q;
            state_d = StDone;
          end
        end else begin
          rlx_d = rlx_q + 1'b1;
        end
      end
      StDone: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ch_ready   = (state_q == StIdle) && !rst;
  assign resp_valid = (state_q == StDone);
  assign cT         = ct_q;
  assign cB         = cb_q;
  assign tigSignal  = tig_q;
  assign resp_bit   = rbit_q;
  assign resp_ones  = rones_q;
  assign resp_err   = rerr_q;

endmodule

// File: tb/tb_apuf_crp_ctrl.sv
// Directed bench: NREP=1 and NREP=7 controllers, each driven by its own arbiter PUF model.
module tb_apuf_crp_ctrl;
  localparam int unsigned NS = 128;
  localparam logic [NS-1:0] D1 = {4{32'hDEADBEEF}};
  localparam logic [NS-1:0] D2 = {4{32'h1234_5678}};
  localparam logic [NS-1:0] D3 = {4{32'hA5A5_0F0F}};
  localparam logic [NS-1:0] D4 = {4{32'hCAFE_F00D}};
  localparam logic [NS-1:0] D5 = {4{32'h0BAD_C0DE}};
  localparam logic [NS-1:0] D6 = {4{32'h5555_AAAA}};
  localparam logic [NS-1:0] D7 = {4{32'h0F1E_2D3C}};

  logic clk = 1'b0;
  logic rst;
  logic [NS-1:0] ch_data;
  always #5 clk = ~clk;

  logic ch_valid1, ch_ready1, tig1, rr1, rb1, resp_valid1, resp_ready1, resp_bit1, resp_err1;
  logic ch_valid7, ch_ready7, tig7, rr7, rb7, resp_valid7, resp_ready7, resp_bit7, resp_err7;
  logic [NS-1:0] cT1, cB1, cT7, cB7;
  logic [7:0] resp_ones1, resp_ones7;

  int n_cmp = 0;
  int n_bad = 0;
  int trig1, trig7;
  logic en1, en7;
  logic [7:0] pat1, pat7;

  apuf_crp_ctrl #(.NSTAGE(NS), .NREP(1), .SETTLE(4), .TIMEOUT(15), .RECOVER(4)) u_dut1 (
    .clk(clk), .rst(rst), .ch_valid(ch_valid1), .ch_ready(ch_ready1), .ch_data(ch_data),
    .cT(cT1), .cB(cB1), .tigSignal(tig1), .respReady(rr1), .respBit(rb1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_bit(resp_bit1),
    .resp_ones(resp_ones1), .resp_err(resp_err1)
  );

  apuf_crp_ctrl #(.NSTAGE(NS), .NREP(7), .SETTLE(4), .TIMEOUT(15), .RECOVER(4)) u_dut7 (
    .clk(clk), .rst(rst), .ch_valid(ch_valid7), .ch_ready(ch_ready7), .ch_data(ch_data),
    .cT(cT7), .cB(cB7), .tigSignal(tig7), .respReady(rr7), .respBit(rb7),
    .resp_valid(resp_valid7), .resp_ready(resp_ready7), .resp_bit(resp_bit7),
    .resp_ones(resp_ones7), .resp_err(resp_err7)
  );

  // PUF models: respReady rises on the 3rd negedge with the trigger high, drops with it.
  // The arbiter bit for evaluation k is pat[k-1].
  initial begin : puf1
    int age;
    int idx;
    logic prev;
    age = 0; prev = 1'b0; rr1 = 1'b0; rb1 = 1'b0;
    forever begin
      @(negedge clk);
      if (tig1 && !prev) trig1++;
      if (tig1 && en1) begin
        age++;
        if (age >= 3) begin
          idx = (trig1 == 0) ? 0 : (trig1 - 1) % 8;
          rb1 = pat1[idx];
          rr1 = 1'b1;
        end
      end else begin
        age = 0;
        rr1 = 1'b0;
      end
      prev = tig1;
    end
  end

  initial begin : puf7
    int age;
    int idx;
    logic prev;
    age = 0; prev = 1'b0; rr7 = 1'b0; rb7 = 1'b0;
    forever begin
      @(negedge clk);
      if (tig7 && !prev) trig7++;
      if (tig7 && en7) begin
        age++;
        if (age >= 3) begin
          idx = (trig7 == 0) ? 0 : (trig7 - 1) % 8;
          rb7 = pat7[idx];
          rr7 = 1'b1;
        end
      end else begin
        age = 0;
        rr7 = 1'b0;
      end
      prev = tig7;
    end
  end

  task automatic send7(input logic [NS-1:0] d);
    @(negedge clk);
    ch_data   = d;
    ch_valid7 = 1'b1;
    @(posedge clk);
    #1;
    ch_valid7 = 1'b0;
  endtask

  task automatic wait_valid7(input int budget, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (n < budget && !ok) begin
      @(posedge clk);
      #1;
      n++;
      if (resp_valid7) ok = 1'b1;
    end
  endtask

  task automatic finish7();
    @(negedge clk);
    resp_ready7 = 1'b1;
    @(posedge clk);
    #1;
    resp_ready7 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (tig1 !== 1'b0 || tig7 !== 1'b0) begin
        n_bad++; $display("FAIL reset_tig: got %b/%b want 0/0", tig1, tig7);
      end
      n_cmp++;
      if (cT7 !== '0 || cB7 !== '0) begin
        n_bad++; $display("FAIL reset_chal: got cT=%h cB=%h want 0", cT7, cB7);
      end
      n_cmp++;
      if (resp_valid7 !== 1'b0 || resp_ones7 !== 8'd0 || resp_bit7 !== 1'b0) begin
        n_bad++; $display("FAIL reset_resp: got v=%b ones=%0d bit=%b want 0", resp_valid7,
                          resp_ones7, resp_bit7);
      end
      n_cmp++;
      if (ch_ready7 !== 1'b0) begin
        n_bad++; $display("FAIL reset_ch_ready: got %b want 0", ch_ready7);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (ch_ready1 !== 1'b1 || ch_ready7 !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_ch_ready: got %b/%b want 1/1", ch_ready1, ch_ready7);
    end
  endtask

  // Accept at edge E0; SETTLE E0..E4, FIRE, trigger high after E5, model raises at
  // negedge after E7, rr_s at E9, SAMPLE after E10, trigger low after E11, rr_s low at
  // E13, four low RELAX cycles, DONE after E17.
  task automatic test_single();
    int n;
    trig1 = 0; en1 = 1'b1; pat1 = 8'h01;
    @(negedge clk);
    ch_data   = D1;
    ch_valid1 = 1'b1;
    @(posedge clk);
    #1;
    ch_valid1 = 1'b0;
    ch_data   = D2;
    n = 0;
    while (n < 100 && resp_valid1 !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (n != 17) begin
      n_bad++; $display("FAIL single_latency: got %0d cycles want 17", n);
    end
    n_cmp++;
    if (resp_bit1 !== 1'b1 || resp_ones1 !== 8'd1 || resp_err1 !== 1'b0) begin
      n_bad++; $display("FAIL single_resp: got bit=%b ones=%0d err=%b want 1/1/0", resp_bit1,
                        resp_ones1, resp_err1);
    end
    n_cmp++;
    if (cT1 !== D1 || cB1 !== D1) begin
      n_bad++; $display("FAIL single_chal: got cT=%h cB=%h want %h", cT1, cB1, D1);
    end
    n_cmp++;
    if (trig1 != 1 || tig1 !== 1'b0) begin
      n_bad++; $display("FAIL single_trig: got %0d pulses tig=%b want 1 pulse tig=0", trig1, tig1);
    end
    @(negedge clk);
    resp_ready1 = 1'b1;
    @(posedge clk);
    #1;
    resp_ready1 = 1'b0;
    n_cmp++;
    if (resp_valid1 !== 1'b0 || ch_ready1 !== 1'b1) begin
      n_bad++; $display("FAIL single_handshake: got valid=%b ready=%b want 0/1", resp_valid1,
                        ch_ready1);
    end
  endtask

  task automatic test_majority();
    int n;
    bit ok;
    // 1,0,1,0,1,0,1 -> four ones
    trig7 = 0; pat7 = 8'h55;
    send7(D2);
    wait_valid7(300, n, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL maj4_timeout: got no resp_valid want resp_valid"); end
    n_cmp++;
    if (resp_bit7 !== 1'b1 || resp_ones7 !== 8'd4 || resp_err7 !== 1'b0) begin
      n_bad++; $display("FAIL maj4_resp: got bit=%b ones=%0d err=%b want 1/4/0", resp_bit7,
                        resp_ones7, resp_err7);
    end
    n_cmp++;
    if (trig7 != 7) begin n_bad++; $display("FAIL maj4_trig: got %0d want 7", trig7); end
    finish7();
    // 0,1,0,1,0,1,0 -> three ones
    trig7 = 0; pat7 = 8'h2A;
    send7(D3);
    wait_valid7(300, n, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL maj3_timeout: got no resp_valid want resp_valid"); end
    n_cmp++;
    if (resp_bit7 !== 1'b0 || resp_ones7 !== 8'd3 || resp_err7 !== 1'b0) begin
      n_bad++; $display("FAIL maj3_resp: got bit=%b ones=%0d err=%b want 0/3/0", resp_bit7,
                        resp_ones7, resp_err7);
    end
    n_cmp++;
    if (trig7 != 7) begin n_bad++; $display("FAIL maj3_trig: got %0d want 7", trig7); end
    finish7();
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    trig7 = 0; en7 = 1'b0; pat7 = 8'hFF;
    send7(D4);
    wait_valid7(300, n, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL tmo_wait: got no resp_valid want resp_valid"); end
    n_cmp++;
    if (resp_err7 !== 1'b1 || resp_bit7 !== 1'b0 || resp_ones7 !== 8'd0) begin
      n_bad++; $display("FAIL tmo_resp: got err=%b bit=%b ones=%0d want 1/0/0", resp_err7,
                        resp_bit7, resp_ones7);
    end
    n_cmp++;
    if (trig7 != 1 || tig7 !== 1'b0) begin
      n_bad++; $display("FAIL tmo_trig: got %0d pulses tig=%b want 1 pulse tig=0", trig7, tig7);
    end
    finish7();
    en7 = 1'b1;
  endtask

  task automatic test_back_to_back_hold();
    int n;
    bit ok;
    bit stable;
    trig7 = 0; pat7 = 8'hFF;
    send7(D6);
    wait_valid7(300, n, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL hold_wait: got no resp_valid want resp_valid"); end
    @(negedge clk);
    ch_data   = D7;
    ch_valid7 = 1'b1;
    stable    = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (resp_valid7 !== 1'b1 || resp_bit7 !== 1'b1 || resp_ones7 !== 8'd7 ||
          resp_err7 !== 1'b0 || ch_ready7 !== 1'b0 || cT7 !== D6 || cB7 !== D6) stable = 1'b0;
    end
    n_cmp++;
    if (!stable) begin
      n_bad++; $display("FAIL hold_stable: got v=%b bit=%b ones=%0d rdy=%b cT=%h want 1/1/7/0/%h",
                        resp_valid7, resp_bit7, resp_ones7, ch_ready7, cT7, D6);
    end
    finish7();
    n_cmp++;
    if (resp_valid7 !== 1'b0 || ch_ready7 !== 1'b1 || cT7 !== D6) begin
      n_bad++; $display("FAIL hold_release: got v=%b rdy=%b cT=%h want 0/1/%h", resp_valid7,
                        ch_ready7, cT7, D6);
    end
    // ch_valid still high: the next edge accepts D7
    @(posedge clk);
    #1;
    ch_valid7 = 1'b0;
    trig7 = 0;
    n_cmp++;
    if (cT7 !== D7 || cB7 !== D7 || ch_ready7 !== 1'b0) begin
      n_bad++; $display("FAIL hold_next_load: got cT=%h rdy=%b want %h/0", cT7, ch_ready7, D7);
    end
    wait_valid7(300, n, ok);
    n_cmp++;
    if (!ok || resp_ones7 !== 8'd7 || resp_bit7 !== 1'b1) begin
      n_bad++; $display("FAIL hold_next_resp: got ok=%b ones=%0d bit=%b want 1/7/1", ok,
                        resp_ones7, resp_bit7);
    end
    finish7();
  endtask

  task automatic test_reset_in_wait();
    int n;
    bit ok;
    bit seen;
    trig7 = 0; pat7 = 8'hFF;
    send7(D4);
    n = 0;
    while (n < 30 && tig7 !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (tig7 !== 1'b1) begin n_bad++; $display("FAIL rstw_trigger: got tig=%b want 1", tig7); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (tig7 !== 1'b0 || resp_valid7 !== 1'b0 || cT7 !== '0) begin
      n_bad++; $display("FAIL rstw_edge: got tig=%b v=%b cT=%h want 0/0/0", tig7, resp_valid7, cT7);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (resp_valid7 === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL rstw_discard: got resp_valid=1 want 0"); end
    trig7 = 0;
    send7(D5);
    wait_valid7(300, n, ok);
    n_cmp++;
    if (!ok || resp_bit7 !== 1'b1 || resp_ones7 !== 8'd7 || resp_err7 !== 1'b0 || cT7 !== D5) begin
      n_bad++; $display("FAIL rstw_next: got ok=%b bit=%b ones=%0d err=%b want 1/1/7/0", ok,
                        resp_bit7, resp_ones7, resp_err7);
    end
    finish7();
  endtask

  initial begin
    ch_data = '0;
    ch_valid1 = 1'b0; resp_ready1 = 1'b0; en1 = 1'b1; pat1 = 8'h00; trig1 = 0;
    ch_valid7 = 1'b0; resp_ready7 = 1'b0; en7 = 1'b1; pat7 = 8'h00; trig7 = 0;
    test_reset();
    test_single();
    test_majority();
    test_timeout();
    test_back_to_back_hold();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
